main_memory_model: RTL and testbench
====================================

# main_memory_model

Cycle-level main-memory model that sits directly downstream of `non_blocking_cache`. It consumes the MSHR miss-request stream (`mm_req`, `mm_req_op`, `mm_req_valid`) and produces the miss-return stream (`mm_ret_data`, `mm_ret_op`, `mm_ret_valid`). Requests are buffered in a request FIFO and issued at a configurable throughput. Each issued request is read from a word-addressed backing array and returned in order after a fixed pipeline latency.

## Interface
- `DATA_WIDTH`, 32: word width of the backing array and of return data.
- `ADDR_WIDTH`, 16: request address width; the backing array holds 2^ADDR_WIDTH words.
- `NUM_OPS`, 32: number of operation IDs; ID width is $clog2(NUM_OPS).
- `LATENCY`, 8: return pipeline depth in stages; must be ≥1.
- `ISSUE_INTERVAL`, 2: minimum number of cycles between two issues; must be ≥1.
- `QUEUE_DEPTH`, 8: request FIFO entries; must be a power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mm_req_valid` in 1: a request is present this cycle. There is no backpressure.
- `mm_req` in ADDR_WIDTH: request word address.
- `mm_req_op` in $clog2(NUM_OPS): operation ID, echoed on return.
- `init_we` in 1: backdoor write enable for the backing array.
- `init_addr` in ADDR_WIDTH: backdoor write address.
- `init_data` in DATA_WIDTH: backdoor write data.
- `mm_ret_valid` out 1: return beat valid; one-cycle pulse per request.
- `mm_ret_data` out DATA_WIDTH: array word at the request address.
- `mm_ret_op` out $clog2(NUM_OPS): echoed operation ID.
- `queue_count` out $clog2(QUEUE_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky flag; set when a request is dropped.

## Operation
- **Enqueue:** if `mm_req_valid` is high at an edge and the FIFO is not full, {addr, op} is written at the tail.
  - If the FIFO is full and no dequeue occurs at that edge, the request is dropped, `overflow` is set, and no return is ever produced for it.
- **Issue condition:** the FIFO is non-empty and the interval counter is 0.
- **On issue:**
  - pop the head;
  - read `mem[addr]`;
  - load pipeline stage 1 with {valid=1, op, data};
  - load the interval counter with ISSUE_INTERVAL-1.
- **Interval counter:** otherwise decrements toward 0 each cycle, saturating at 0.
- **Pipeline:** LATENCY stages, shifting every cycle. There is no stall, because the cache never backpressures returns. The stage-LATENCY registers drive `mm_ret_*` directly.
- **Ordering:** returns appear in request order. At most one return per cycle.
- **Full and dequeue at the same edge:** enqueue is accepted, the request is not dropped, and `queue_count` is unchanged.
- **Empty FIFO:** a request arriving at an edge cannot issue at that same edge. There is no bypass.
- **Backdoor write:** `init_we` writes `mem[init_addr]` at the edge.
  - An issue reading the same address at the same edge returns the old value (read-before-write).
- **Backing array:** not reset; contents persist across reset.
- **Idle outputs:** when stage LATENCY is invalid, `mm_ret_data` and `mm_ret_op` are driven 0.

## Timing
- **Reset:** asserting `reset` low immediately clears FIFO pointers, `queue_count`=0, all pipeline valids, `mm_ret_valid`=0, `mm_ret_data`=0, `mm_ret_op`=0, the interval counter (=0) and `overflow`=0.
  - In-flight and queued requests are discarded.
  - Release is synchronous to `clk` via the usual deassertion synchronizer upstream.
- **Minimum latency:** with an empty FIFO and interval counter 0, a request present in cycle t returns with `mm_ret_valid` high in cycle t+LATENCY+1.
- **Queued requests:** the k-th queued request issues ISSUE_INTERVAL·k cycles after the first issue, if sustained.
- **Throughput:** one request per ISSUE_INTERVAL cycles. Sustained input faster than that fills the FIFO and sets `overflow`.
- **`queue_count`:** updates at the same edge as enqueue/dequeue.

## Structure
- **Package `mm_pkg`:** holds the `mm_req_t` struct {addr, op}, the `mm_ret_t` struct {valid, op, data}, and default-parameter localparams shared with `non_blocking_cache`.
- **Sub-module `mm_req_fifo`:** parameterised on element type and depth.
  - Interface: push/pop/full/empty/count; pointers one bit wider than the index for full/empty detection.
  - Pointer wrap-around is natural modulo 2·QUEUE_DEPTH.
- **Top level:** holds the interval counter, the backing array and the return pipeline.

## Test plan
- **Single request latency:** preload `mem[0x0010]`=0xDEADBEEF; request addr 0x0010, op 5 in cycle 3 (LATENCY=8) -> `mm_ret_valid` only in cycle 12 with data 0xDEADBEEF, op 5.
- **Back-to-back spacing:** ISSUE_INTERVAL=2; requests ops 1,2,3 in consecutive cycles from cycle 0 -> returns in order 1,2,3 in cycles 9, 11, 13; `queue_count` peaks at 2.
- **Overflow:** QUEUE_DEPTH=8, ISSUE_INTERVAL=4, 12 consecutive requests -> exactly the dropped ones absent from returns, `overflow`=1 and stays high, every surviving op returned once in order.
- **Full with simultaneous pop:** fill the FIFO, then present a request at the issue edge -> accepted, `queue_count` stays 8, no overflow.
- **Read-before-write:** `init_we` to 0x0020 with 0x1 at the same edge as an issue of 0x0020 (old 0x0) -> return data 0x0; the next request to 0x0020 returns 0x1.
- **Reset mid-operation:** 5 requests queued or in flight, then assert `reset` -> all outputs 0 immediately, no returns after release, backing array contents intact.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and default sizing for the main-memory model and the
// non-blocking cache that drives it.
package mm_pkg;

    localparam int MM_DATA_WIDTH     = 32;
    localparam int MM_ADDR_WIDTH     = 16;
    localparam int MM_NUM_OPS        = 32;
    localparam int MM_OP_WIDTH       = $clog2(MM_NUM_OPS);
    localparam int MM_LATENCY        = 8;
    localparam int MM_ISSUE_INTERVAL = 2;
    localparam int MM_QUEUE_DEPTH    = 8;

    // Miss request as produced by the cache MSHRs.
    typedef struct packed {
        logic [MM_ADDR_WIDTH-1:0] addr;
        logic [MM_OP_WIDTH-1:0]   op;
    } mm_req_t;

    // Miss return beat as consumed by the cache.
    typedef struct packed {
        logic                     valid;
        logic [MM_OP_WIDTH-1:0]   op;
        logic [MM_DATA_WIDTH-1:0] data;
    } mm_ret_t;

endpackage

// File: rtl/mm_req_fifo.sv
// Request FIFO for the main-memory model. Pointers carry one extra bit so
// full and empty are told apart; they wrap naturally modulo 2*DEPTH.
// A push into a full FIFO is accepted when a pop happens at the same edge.
module mm_req_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       data_i,
    output T                       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int IDX_W = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [IDX_W:0] wptr_q, wptr_d;
    logic [IDX_W:0] rptr_q, rptr_d;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                     (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rptr_q[IDX_W-1:0]];

    // Advance pointers on accepted push/pop.
    always_comb begin
        wptr_d = wptr_q + {{IDX_W{1'b0}}, do_push};
        rptr_d = rptr_q + {{IDX_W{1'b0}}, do_pop};
    end

    // Pointer state; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[IDX_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/main_memory_model.sv
// Cycle-level main memory behind the non-blocking cache: buffers miss
// requests, issues them no faster than one per ISSUE_INTERVAL cycles, reads
// a word-addressed backing array and returns data in order LATENCY stages later.
module main_memory_model
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH     = MM_DATA_WIDTH,
    parameter int ADDR_WIDTH     = MM_ADDR_WIDTH,
    parameter int NUM_OPS        = MM_NUM_OPS,
    parameter int LATENCY        = MM_LATENCY,
    parameter int ISSUE_INTERVAL = MM_ISSUE_INTERVAL,
    parameter int QUEUE_DEPTH    = MM_QUEUE_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mm_req_valid,
    input  logic [ADDR_WIDTH-1:0]          mm_req,
    input  logic [$clog2(NUM_OPS)-1:0]     mm_req_op,
    input  logic                           init_we,
    input  logic [ADDR_WIDTH-1:0]          init_addr,
    input  logic [DATA_WIDTH-1:0]          init_data,
    output logic                           mm_ret_valid,
    output logic [DATA_WIDTH-1:0]          mm_ret_data,
    output logic [$clog2(NUM_OPS)-1:0]     mm_ret_op,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           overflow
);

    localparam int OP_W  = $clog2(NUM_OPS);
    localparam int CNT_W = $clog2(ISSUE_INTERVAL + 1);

    // Same layout as mm_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [OP_W-1:0]       op;
    } req_t;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    req_t                  push_req;
    req_t                  head_req;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  issue;
    logic [CNT_W-1:0]      intv_q, intv_d;
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [OP_W-1:0]       op_q   [LATENCY];
    logic [DATA_WIDTH-1:0] data_q [LATENCY];
    logic                  overflow_q, overflow_d;

    assign push_req = '{addr: mm_req, op: mm_req_op};
    assign issue    = !fifo_empty && (intv_q == '0);

    mm_req_fifo #(
        .T     (req_t),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (mm_req_valid),
        .pop_i   (issue),
        .data_i  (push_req),
        .data_o  (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (queue_count)
    );

    // Interval counter reloads on issue and otherwise drains to zero; the
    // overflow flag latches any request dropped at a full FIFO without a pop.
    always_comb begin
        intv_d = intv_q;
        if (issue) begin
            intv_d = CNT_W'(ISSUE_INTERVAL - 1);
        end else if (intv_q != '0) begin
            intv_d = intv_q - 1'b1;
        end
        overflow_d = overflow_q | (mm_req_valid & fifo_full & ~issue);
    end

    // Valid bits shift one stage per cycle; stage 0 is loaded by an issue.
    always_comb begin
        vld_d[0] = issue;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Control state: interval counter, pipeline valids, sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intv_q     <= '0;
            vld_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            intv_q     <= intv_d;
            vld_q      <= vld_d;
            overflow_q <= overflow_d;
        end
    end

    // Return payload shifts alongside the valids; stage 0 reads the array
    // every cycle, and an issue captures the word before any same-edge write.
    always_ff @(posedge clk) begin
        op_q[0]   <= head_req.op;
        data_q[0] <= mem_q[head_req.addr];
        for (int i = 1; i < LATENCY; i++) begin
            op_q[i]   <= op_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    // Backdoor write port; the array keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= init_data;
        end
    end

    assign mm_ret_valid = vld_q[LATENCY-1];
    assign mm_ret_op    = vld_q[LATENCY-1] ? op_q[LATENCY-1]   : '0;
    assign mm_ret_data  = vld_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_main_memory_model.sv
// Directed-plus-random bench for main_memory_model. A queue-based reference
// model tracks pending requests, issue spacing and expected return cycles.
module tb_main_memory_model;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int NOPS  = 32;
    localparam int OPW   = 5;
    localparam int LAT   = 8;
    localparam int INTV  = 2;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           mm_req_valid;
    logic [AW-1:0]  mm_req;
    logic [OPW-1:0] mm_req_op;
    logic           init_we;
    logic [AW-1:0]  init_addr;
    logic [DW-1:0]  init_data;
    logic           mm_ret_valid;
    logic [DW-1:0]  mm_ret_data;
    logic [OPW-1:0] mm_ret_op;
    logic [3:0]     queue_count;
    logic           overflow;

    main_memory_model #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_OPS        (NOPS),
        .LATENCY        (LAT),
        .ISSUE_INTERVAL (INTV),
        .QUEUE_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mm_req_valid (mm_req_valid),
        .mm_req       (mm_req),
        .mm_req_op    (mm_req_op),
        .init_we      (init_we),
        .init_addr    (init_addr),
        .init_data    (init_data),
        .mm_ret_valid (mm_ret_valid),
        .mm_ret_data  (mm_ret_data),
        .mm_ret_op    (mm_ret_op),
        .queue_count  (queue_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [OPW-1:0] op;
    } req_s;

    typedef struct {
        int             cyc;
        logic [OPW-1:0] op;
        logic [DW-1:0]  data;
    } ret_s;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    req_s          mq[$];
    ret_s          eq[$];
    logic [DW-1:0] mref [64];
    int            m_cnt    = 0;
    bit            m_ovf    = 1'b0;
    logic [DW-1:0] last_data;
    int            last_ret_cyc = 0;
    int            ret_seen     = 0;
    int            log_cyc[$];
    int            log_op[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (eq.size() > 0) && (eq[0].cyc == cyc);
        chk("ret_valid", 32'(mm_ret_valid), 32'(ev));
        if (ev) begin
            chk("ret_data", mm_ret_data, eq[0].data);
            chk("ret_op", 32'(mm_ret_op), 32'(eq[0].op));
            void'(eq.pop_front());
        end else begin
            chk("idle_data", mm_ret_data, 32'h0);
            chk("idle_op", 32'(mm_ret_op), 32'h0);
        end
        chk("queue_count", 32'(queue_count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mm_ret_valid) begin
            last_data    = mm_ret_data;
            last_ret_cyc = cyc;
            ret_seen++;
            log_cyc.push_back(cyc);
            log_op.push_back(int'(mm_ret_op));
        end
    endtask

    // One clock cycle: drive inputs, advance the model over the closing edge,
    // then check the DUT on the following falling edge.
    task automatic tick(input bit v, input logic [AW-1:0] a, input logic [OPW-1:0] o,
                        input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit   iss;
        req_s r;
        ret_s e;
        mm_req_valid = v;
        mm_req       = a;
        mm_req_op    = o;
        init_we      = we;
        init_addr    = wa;
        init_data    = wd;
        iss = (mq.size() > 0) && (m_cnt == 0);
        if (iss) begin
            r = mq.pop_front();
            e = '{cyc: cyc + LAT, op: r.op, data: mref[r.addr[5:0]]};
            eq.push_back(e);
            m_cnt = INTV - 1;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end
        if (v) begin
            if (mq.size() < DEPTH) begin
                r = '{addr: a, op: o};
                mq.push_back(r);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (we) mref[wa[5:0]] = wd;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mm_req_valid = 1'b0;
        init_we      = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic req(input logic [AW-1:0] a, input logic [OPW-1:0] o);
        tick(1'b1, a, o, 1'b0, '0, '0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((eq.size() > 0 || mq.size() > 0) && n < budget) begin
            idle(1);
            n++;
        end
        chk("drain_timeout", 32'(eq.size() + mq.size()), 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(mm_ret_valid), 32'h0);
        chk({tag, "_data"}, mm_ret_data, 32'h0);
        chk({tag, "_op"}, 32'(mm_ret_op), 32'h0);
        chk({tag, "_count"}, 32'(queue_count), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
    endtask

    task automatic rst_tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk_reset_outputs("in_reset");
    endtask

    // Asynchronous assertion between edges; release after a falling edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk_reset_outputs("reset_immediate");
        mq.delete();
        eq.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        rst_tick();
        rst_tick();
        reset = 1'b1;
    endtask

    initial begin
        int            t0;
        int            rs0;
        int            peak;
        bit            hit;
        logic [DW-1:0] d;

        reset        = 1'b0;
        mm_req_valid = 1'b0;
        mm_req       = '0;
        mm_req_op    = '0;
        init_we      = 1'b0;
        init_addr    = '0;
        init_data    = '0;

        rst_tick();
        rst_tick();
        reset = 1'b1;

        // Preload words 0..63 through the backdoor.
        for (int i = 0; i < 64; i++) begin
            if (i == 16)      d = 32'hDEADBEEF;
            else if (i == 32) d = 32'h0;
            else              d = $urandom;
            tick(1'b0, '0, '0, 1'b1, AW'(i), d);
        end
        idle(2);

        // Single request: minimum latency LATENCY+1.
        t0  = cyc;
        rs0 = ret_seen;
        req(16'h0010, 5'd5);
        for (int i = 0; i < 20 && ret_seen == rs0; i++) idle(1);
        chk("lat1_cycles", 32'(last_ret_cyc - t0), 32'(LAT + 1));
        chk("lat1_data", last_data, 32'hDEADBEEF);
        drain(40);
        idle(2);

        // Back-to-back requests spaced by the issue interval.
        log_cyc.delete();
        log_op.delete();
        t0   = cyc;
        peak = 0;
        for (int i = 1; i <= 3; i++) begin
            req(AW'(i), OPW'(i));
            if (int'(queue_count) > peak) peak = int'(queue_count);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (int'(queue_count) > peak) peak = int'(queue_count);
        end
        drain(40);
        chk("b2b_peak", 32'(peak), 32'd2);
        chk("b2b_nret", 32'(log_cyc.size()), 32'd3);
        if (log_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("b2b_cycle", 32'(log_cyc[i] - t0), 32'(9 + 2 * i));
                chk("b2b_op", 32'(log_op[i]), 32'(i + 1));
            end
        end

        // Sustained input above throughput: drops and sticky overflow.
        for (int i = 0; i < 20; i++) req(AW'($urandom_range(0, 63)), OPW'(i));
        chk("ovf_set", 32'(overflow), 32'h1);
        drain(80);
        idle(3);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Full FIFO with a push only on the edges where a pop also happens.
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (mq.size() == DEPTH && m_cnt == 0) hit = 1'b1;
            if (mq.size() < DEPTH || m_cnt == 0) req(AW'($urandom_range(0, 63)), OPW'(i));
            else idle(1);
        end
        chk("full_pop_hit", 32'(hit), 32'h1);
        chk("full_pop_count", 32'(queue_count), 32'd8);
        chk("full_pop_ovf", 32'(overflow), 32'h0);
        drain(80);
        idle(2);

        // Read-before-write on the issue edge.
        req(16'h0020, 5'd7);
        tick(1'b0, '0, '0, 1'b1, 16'h0020, 32'h1);
        drain(40);
        chk("rbw_old", last_data, 32'h0);
        req(16'h0020, 5'd8);
        drain(40);
        chk("rbw_new", last_data, 32'h1);

        // Reset with requests queued and in flight.
        for (int i = 0; i < 5; i++) req(AW'(i + 40), OPW'(i + 20));
        idle(3);
        do_reset();
        rs0 = ret_seen;
        idle(20);
        chk("no_ret_after_reset", 32'(ret_seen - rs0), 32'h0);
        req(16'h0010, 5'd9);
        drain(40);
        chk("mem_persist", last_data, 32'hDEADBEEF);

        // Random traffic with occasional backdoor writes.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) < 45), AW'($urandom_range(0, 63)), OPW'($urandom_range(0, NOPS - 1)),
                 ($urandom_range(0, 9) == 0), AW'($urandom_range(0, 63)), $urandom);
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
